// File: rtl/csr_register_file.sv
// RV32 machine/supervisor CSR file: privileged CSRs, current privilege level,
// trap entry and MRET/SRET redirect for the pipeline, plus satp/SUM for the MMU.
module csr_register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_wen,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_ren,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic [31:0] csr_status,
  input  logic [31:0] csr_trapPC,
  input  logic [4:0]  csr_trapID,
  input  logic [31:0] faulting_inst,
  input  logic [31:0] faulting_va_IMEM,
  input  logic [31:0] faulting_va_DMEM,
  input  logic        csr_ecall,
  input  logic        csr_mret,
  input  logic        csr_sret,
  output logic        csr_branch_signal,
  output logic [31:0] csr_branch_address,
  input  logic [11:0] csr_addr_EX,
  input  logic [11:0] csr_addr_MEM,
  input  logic [31:0] csr_rdata_EX,
  input  logic [31:0] csr_rdata_MEM,
  input  logic        msip,
  input  logic        mtip,
  input  logic        meip,
  output logic [31:0] satp_o,
  output logic [1:0]  priv_o,
  output logic [31:0] sstatus_sum
);

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [11:0] A_SSTATUS  = 12'h100;
  localparam logic [11:0] A_SIE      = 12'h104;
  localparam logic [11:0] A_STVEC    = 12'h105;
  localparam logic [11:0] A_SSCRATCH = 12'h140;
  localparam logic [11:0] A_SEPC     = 12'h141;
  localparam logic [11:0] A_SCAUSE   = 12'h142;
  localparam logic [11:0] A_STVAL    = 12'h143;
  localparam logic [11:0] A_SIP      = 12'h144;
  localparam logic [11:0] A_SATP     = 12'h180;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MEDELEG  = 12'h302;
  localparam logic [11:0] A_MIDELEG  = 12'h303;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [31:0] MISA_VAL     = 32'h4014_1101;
  localparam logic [31:0] MSTATUS_MASK = 32'h000C_19AA;
  localparam logic [31:0] SSTATUS_MASK = 32'h000C_0122;
  localparam logic [31:0] SIE_MASK     = 32'h0000_0222;
  localparam logic [31:0] EPC_MASK     = 32'hFFFF_FFFC;

  logic [1:0]  r_priv;
  logic [31:0] r_mstatus, r_mie, r_medeleg, r_mideleg, r_mtvec, r_mscratch;
  logic [31:0] r_mepc, r_mcause, r_mtval, r_mcycle;
  logic [31:0] r_stvec, r_sscratch, r_sepc, r_scause, r_stval, r_satp;

  logic [31:0] w_mip, w_irq_pend, w_cause, w_tval, w_rd_val;
  logic [31:0] w_tgt_stored, w_tgt_raw, w_mstatus_evt;
  logic [11:0] w_tgt_addr;
  logic [3:0]  w_irq_code;
  logic        w_irq_take, w_trap, w_is_irq, w_to_s, w_mret, w_sret;

  assign w_mip      = {20'd0, meip, 3'd0, mtip, 3'd0, msip, 3'd0};
  assign w_irq_pend = r_mie & w_mip;
  assign w_irq_take = (w_irq_pend != 32'd0) && ((r_priv != PRIV_M) || r_mstatus[3]);
  assign w_irq_code = w_irq_pend[11] ? 4'd11 : (w_irq_pend[3] ? 4'd3 : 4'd7);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves a latch.
    w_trap   = 1'b0;
    w_is_irq = 1'b0;
    w_mret   = 1'b0;
    w_sret   = 1'b0;
    w_cause  = 32'd0;
    w_tval   = 32'd0;
    if (csr_trapID != 5'd0) begin
      w_trap  = 1'b1;
      w_cause = {27'd0, csr_trapID};
    end else if (csr_ecall) begin
      w_trap = 1'b1;
      case (r_priv)
        PRIV_U:  w_cause = 32'd8;
        PRIV_S:  w_cause = 32'd9;
        default: w_cause = 32'd11;
      endcase
    end else if (csr_mret) begin
      w_mret = 1'b1;
    end else if (csr_sret) begin
      w_sret = 1'b1;
    end else if (w_irq_take) begin
      w_trap   = 1'b1;
      w_is_irq = 1'b1;
      w_cause  = {1'b1, 27'd0, w_irq_code};
    end
    w_to_s = w_trap && !w_is_irq && (r_priv != PRIV_M) && r_medeleg[w_cause[4:0]];
    if (w_trap && !w_is_irq) begin
      case (w_cause[4:0])
        5'd2:                              w_tval = faulting_inst;
        5'd1, 5'd12:                       w_tval = faulting_va_IMEM;
        5'd4, 5'd5, 5'd6, 5'd7, 5'd13, 5'd15: w_tval = faulting_va_DMEM;
        default:                           w_tval = 32'd0;
      endcase
    end
  end

  // Redirect target: pick the vector/epc in use, then prefer in-flight writes (EX over MEM).
  always_comb begin
    w_tgt_addr   = 12'd0;
    w_tgt_stored = 32'd0;
    if (w_trap && w_to_s) begin
      w_tgt_addr = A_STVEC;  w_tgt_stored = r_stvec;
    end else if (w_trap) begin
      w_tgt_addr = A_MTVEC;  w_tgt_stored = r_mtvec;
    end else if (w_mret) begin
      w_tgt_addr = A_MEPC;   w_tgt_stored = r_mepc;
    end else if (w_sret) begin
      w_tgt_addr = A_SEPC;   w_tgt_stored = r_sepc;
    end
    if ((csr_addr_EX != 12'd0) && (csr_addr_EX == w_tgt_addr))
      w_tgt_raw = csr_rdata_EX;
    else if ((csr_addr_MEM != 12'd0) && (csr_addr_MEM == w_tgt_addr))
      w_tgt_raw = csr_rdata_MEM;
    else
      w_tgt_raw = w_tgt_stored;
  end

  assign csr_branch_signal  = w_trap || w_mret || w_sret;
  assign csr_branch_address = csr_branch_signal ? (w_tgt_raw & EPC_MASK) : 32'd0;

  always_comb begin
    w_mstatus_evt = r_mstatus;
    if (w_trap && !w_to_s) begin
      w_mstatus_evt[7]     = r_mstatus[3];
      w_mstatus_evt[3]     = 1'b0;
      w_mstatus_evt[12:11] = r_priv;
    end else if (w_trap) begin
      w_mstatus_evt[5] = r_mstatus[1];
      w_mstatus_evt[1] = 1'b0;
      w_mstatus_evt[8] = r_priv[0];
    end else if (w_mret) begin
      w_mstatus_evt[3]     = r_mstatus[7];
      w_mstatus_evt[7]     = 1'b1;
      w_mstatus_evt[12:11] = PRIV_U;
    end else if (w_sret) begin
      w_mstatus_evt[1] = r_mstatus[5];
      w_mstatus_evt[5] = 1'b1;
      w_mstatus_evt[8] = 1'b0;
    end
  end

  always_comb begin
    case (csr_raddr)
      A_SSTATUS:  w_rd_val = r_mstatus & SSTATUS_MASK;
      A_SIE:      w_rd_val = r_mie & SIE_MASK;
      A_STVEC:    w_rd_val = r_stvec;
      A_SSCRATCH: w_rd_val = r_sscratch;
      A_SEPC:     w_rd_val = r_sepc;
      A_SCAUSE:   w_rd_val = r_scause;
      A_STVAL:    w_rd_val = r_stval;
      A_SIP:      w_rd_val = w_mip & SIE_MASK;
      A_SATP:     w_rd_val = r_satp;
      A_MSTATUS:  w_rd_val = r_mstatus;
      A_MISA:     w_rd_val = MISA_VAL;
      A_MEDELEG:  w_rd_val = r_medeleg;
      A_MIDELEG:  w_rd_val = r_mideleg;
      A_MIE:      w_rd_val = r_mie;
      A_MTVEC:    w_rd_val = r_mtvec;
      A_MSCRATCH: w_rd_val = r_mscratch;
      A_MEPC:     w_rd_val = r_mepc;
      A_MCAUSE:   w_rd_val = r_mcause;
      A_MTVAL:    w_rd_val = r_mtval;
      A_MIP:      w_rd_val = w_mip;
      A_MCYCLE,
      A_CYCLE:    w_rd_val = r_mcycle;
      A_MHARTID:  w_rd_val = 32'd0;
      default:    w_rd_val = 32'd0;
    endcase
  end

  assign csr_rdata   = csr_ren ? w_rd_val : 32'd0;
  assign csr_status  = r_mstatus;
  assign satp_o      = r_satp;
  assign priv_o      = r_priv;
  assign sstatus_sum = {31'd0, r_mstatus[18]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_priv     <= PRIV_M;
      r_mstatus  <= '0;  r_mie      <= '0;  r_medeleg <= '0;  r_mideleg <= '0;
      r_mtvec    <= '0;  r_mscratch <= '0;  r_mepc    <= '0;  r_mcause  <= '0;
      r_mtval    <= '0;  r_mcycle   <= '0;  r_stvec   <= '0;  r_sscratch <= '0;
      r_sepc     <= '0;  r_scause   <= '0;  r_stval   <= '0;  r_satp    <= '0;
    end else begin
      r_mcycle <= r_mcycle + 32'd1;
      if (csr_wen) begin
        case (csr_waddr)
          A_SSTATUS:  r_mstatus  <= (r_mstatus & ~SSTATUS_MASK) | (csr_wdata & SSTATUS_MASK);
          A_SIE:      r_mie      <= (r_mie & ~SIE_MASK) | (csr_wdata & SIE_MASK);
          A_STVEC:    r_stvec    <= csr_wdata;
          A_SSCRATCH: r_sscratch <= csr_wdata;
          A_SEPC:     r_sepc     <= csr_wdata & EPC_MASK;
          A_SCAUSE:   r_scause   <= csr_wdata;
          A_STVAL:    r_stval    <= csr_wdata;
          A_SATP:     r_satp     <= csr_wdata;
          A_MSTATUS:  r_mstatus  <= csr_wdata & MSTATUS_MASK;
          A_MEDELEG:  r_medeleg  <= csr_wdata;
          A_MIDELEG:  r_mideleg  <= csr_wdata;
          A_MIE:      r_mie      <= csr_wdata;
          A_MTVEC:    r_mtvec    <= csr_wdata;
          A_MSCRATCH: r_mscratch <= csr_wdata;
          A_MEPC:     r_mepc     <= csr_wdata & EPC_MASK;
          A_MCAUSE:   r_mcause   <= csr_wdata;
          A_MTVAL:    r_mtval    <= csr_wdata;
          A_MCYCLE:   r_mcycle   <= csr_wdata;
          default:    ;
        endcase
      end
      // NOTE: the last non-blocking assignment in a block wins, so trap/xRET
      // updates below take precedence over a same-cycle write to those registers.
      if (w_trap && !w_to_s) begin
        r_mepc   <= csr_trapPC & EPC_MASK;
        r_mcause <= w_cause;
        r_mtval  <= w_tval;
        r_priv   <= PRIV_M;
      end else if (w_trap) begin
        r_sepc   <= csr_trapPC & EPC_MASK;
        r_scause <= w_cause;
        r_stval  <= w_tval;
        r_priv   <= PRIV_S;
      end else if (w_mret) begin
        r_priv <= r_mstatus[12:11];
      end else if (w_sret) begin
        r_priv <= {1'b0, r_mstatus[8]};
      end
      if (csr_branch_signal) r_mstatus <= w_mstatus_evt;
    end
  end

endmodule

// File: tb/tb_csr_register_file.sv
// Self-checking bench for csr_register_file: directed scenarios with literal
// expectations, then randomized traffic compared against a CSR-level model.
module tb_csr_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_wen, csr_ren, csr_ecall, csr_mret, csr_sret;
  logic [11:0] csr_waddr, csr_raddr, csr_addr_EX, csr_addr_MEM;
  logic [31:0] csr_wdata, csr_rdata, csr_status, csr_trapPC;
  logic [4:0]  csr_trapID;
  logic [31:0] faulting_inst, faulting_va_IMEM, faulting_va_DMEM;
  logic        csr_branch_signal;
  logic [31:0] csr_branch_address, csr_rdata_EX, csr_rdata_MEM;
  logic        msip, mtip, meip;
  logic [31:0] satp_o, sstatus_sum;
  logic [1:0]  priv_o;

  always #5 clk = ~clk;

  csr_register_file dut (
    .clk(clk), .rst(rst),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_status(csr_status), .csr_trapPC(csr_trapPC), .csr_trapID(csr_trapID),
    .faulting_inst(faulting_inst), .faulting_va_IMEM(faulting_va_IMEM),
    .faulting_va_DMEM(faulting_va_DMEM),
    .csr_ecall(csr_ecall), .csr_mret(csr_mret), .csr_sret(csr_sret),
    .csr_branch_signal(csr_branch_signal), .csr_branch_address(csr_branch_address),
    .csr_addr_EX(csr_addr_EX), .csr_addr_MEM(csr_addr_MEM),
    .csr_rdata_EX(csr_rdata_EX), .csr_rdata_MEM(csr_rdata_MEM),
    .msip(msip), .mtip(mtip), .meip(meip),
    .satp_o(satp_o), .priv_o(priv_o), .sstatus_sum(sstatus_sum)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural CSR contents by address, plus the privilege level.
  logic [31:0] m [0:4095];
  logic [1:0]  m_priv;
  bit          m_valid = 1'b0;

  localparam logic [31:0] MS_MASK = 32'h000C_19AA;
  localparam logic [31:0] SS_MASK = 32'h000C_0122;

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) m[i] = 32'd0;
    m_priv  = 2'b11;
    m_valid = 1'b1;
  endtask

  function automatic logic [31:0] mip_now();
    return (32'(meip) << 11) | (32'(mtip) << 7) | (32'(msip) << 3);
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h100: return m[12'h300] & SS_MASK;
      12'h104: return m[12'h304] & 32'h222;
      12'h144: return mip_now() & 32'h222;
      12'h301: return 32'h4014_1101;
      12'h344: return mip_now();
      12'hC00: return m[12'hB00];
      12'h105, 12'h140, 12'h141, 12'h142, 12'h143, 12'h180, 12'h300, 12'h302,
      12'h303, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00:
        return m[a];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h100: m[12'h300] = (m[12'h300] & ~SS_MASK) | (d & SS_MASK);
      12'h104: m[12'h304] = (m[12'h304] & ~32'h222) | (d & 32'h222);
      12'h300: m[12'h300] = d & MS_MASK;
      12'h141, 12'h341: m[a] = d & ~32'h3;
      12'h105, 12'h140, 12'h142, 12'h143, 12'h180, 12'h302, 12'h303, 12'h304,
      12'h305, 12'h340, 12'h342, 12'h343, 12'hB00: m[a] = d;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] tval_for(input logic [31:0] c);
    case (c)
      32'd2:                                      return faulting_inst;
      32'd1, 32'd12:                              return faulting_va_IMEM;
      32'd4, 32'd5, 32'd6, 32'd7, 32'd13, 32'd15: return faulting_va_DMEM;
      default:                                    return 32'd0;
    endcase
  endfunction

  // kind: 0 none, 1 trap to M, 2 trap to S, 3 MRET, 4 SRET
  task automatic model_event(output int kind, output logic [31:0] cause,
                             output logic [31:0] tval, output logic [31:0] tgt);
    logic [31:0] pend, vec;
    logic [11:0] va;
    bit irq;
    kind = 0; cause = 32'd0; tval = 32'd0; tgt = 32'd0; irq = 1'b0;
    pend = m[12'h304] & mip_now();
    if (csr_trapID != 5'd0) begin
      kind = 1; cause = 32'(csr_trapID);
    end else if (csr_ecall) begin
      kind = 1;
      cause = (m_priv == 2'b00) ? 32'd8 : ((m_priv == 2'b01) ? 32'd9 : 32'd11);
    end else if (csr_mret) begin
      kind = 3;
    end else if (csr_sret) begin
      kind = 4;
    end else if (pend != 32'd0 && (m_priv != 2'b11 || m[12'h300][3])) begin
      kind = 1; irq = 1'b1;
      cause = 32'h8000_0000 | (pend[11] ? 32'd11 : (pend[3] ? 32'd3 : 32'd7));
    end
    if (kind == 1 && !irq) begin
      if (m_priv != 2'b11 && m[12'h302][cause[4:0]]) kind = 2;
      tval = tval_for(cause);
    end
    case (kind)
      1: va = 12'h305;
      2: va = 12'h105;
      3: va = 12'h341;
      default: va = 12'h141;
    endcase
    if (kind != 0) begin
      if (csr_addr_EX != 12'd0 && csr_addr_EX == va)        vec = csr_rdata_EX;
      else if (csr_addr_MEM != 12'd0 && csr_addr_MEM == va) vec = csr_rdata_MEM;
      else                                                  vec = m[va];
      tgt = vec & ~32'h3;
    end
  endtask

  task automatic model_commit();
    int kind;
    logic [31:0] cause, tval, tgt, st;
    if (rst) begin
      model_reset();
      return;
    end
    model_event(kind, cause, tval, tgt);
    st = m[12'h300];
    m[12'hB00] = m[12'hB00] + 32'd1;
    if (csr_wen) model_write(csr_waddr, csr_wdata);
    case (kind)
      1: begin
        m[12'h341] = csr_trapPC & ~32'h3; m[12'h342] = cause; m[12'h343] = tval;
        st[7] = st[3]; st[3] = 1'b0; st[12:11] = m_priv;
        m[12'h300] = st; m_priv = 2'b11;
      end
      2: begin
        m[12'h141] = csr_trapPC & ~32'h3; m[12'h142] = cause; m[12'h143] = tval;
        st[5] = st[1]; st[1] = 1'b0; st[8] = m_priv[0];
        m[12'h300] = st; m_priv = 2'b01;
      end
      3: begin
        m_priv = st[12:11];
        st[3] = st[7]; st[7] = 1'b1; st[12:11] = 2'b00;
        m[12'h300] = st;
      end
      4: begin
        m_priv = {1'b0, st[8]};
        st[1] = st[5]; st[5] = 1'b1; st[8] = 1'b0;
        m[12'h300] = st;
      end
      default: ;
    endcase
  endtask

  task automatic compare();
    int kind;
    logic [31:0] cause, tval, tgt;
    model_event(kind, cause, tval, tgt);
    check("branch_signal", {31'd0, csr_branch_signal}, {31'd0, kind != 0});
    check("branch_address", csr_branch_address, tgt);
    check("rdata", csr_rdata, csr_ren ? model_read(csr_raddr) : 32'd0);
    check("status", csr_status, m[12'h300]);
    check("satp_o", satp_o, m[12'h180]);
    check("priv_o", {30'd0, priv_o}, {30'd0, m_priv});
    check("sstatus_sum", sstatus_sum, {31'd0, m[12'h300][18]});
  endtask

  task automatic idle();
    rst = 1'b0; csr_wen = 1'b0; csr_waddr = 12'd0; csr_wdata = 32'd0;
    csr_ren = 1'b0; csr_raddr = 12'd0; csr_trapPC = 32'd0; csr_trapID = 5'd0;
    faulting_inst = 32'd0; faulting_va_IMEM = 32'd0; faulting_va_DMEM = 32'd0;
    csr_ecall = 1'b0; csr_mret = 1'b0; csr_sret = 1'b0;
    csr_addr_EX = 12'd0; csr_addr_MEM = 12'd0; csr_rdata_EX = 32'd0; csr_rdata_MEM = 32'd0;
    msip = 1'b0; mtip = 1'b0; meip = 1'b0;
  endtask

  task automatic settle();
    #1;
    if (m_valid) compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    idle(); csr_wen = 1'b1; csr_waddr = a; csr_wdata = d;
    settle(); tick();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
    idle(); csr_ren = 1'b1; csr_raddr = a;
    settle(); check(nm, csr_rdata, exp); tick();
  endtask

  logic [11:0] addrs [0:25] = '{12'h100, 12'h104, 12'h105, 12'h140, 12'h141, 12'h142,
                                12'h143, 12'h144, 12'h180, 12'h300, 12'h301, 12'h302,
                                12'h303, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'h344, 12'hB00, 12'hC00, 12'hF14, 12'h7C0,
                                12'h3A0, 12'h000};
  logic [11:0] fwd_addrs [0:5] = '{12'h000, 12'h305, 12'h105, 12'h341, 12'h141, 12'h300};

  initial begin
    idle(); rst = 1'b1;
    settle(); tick();
    settle(); tick();

    // Reset state
    idle(); csr_ren = 1'b1; csr_raddr = 12'h301;
    settle();
    check("reset_misa", csr_rdata, 32'h4014_1101);
    check("reset_priv", {30'd0, priv_o}, 32'd3);
    check("reset_branch", {31'd0, csr_branch_signal}, 32'd0);
    check("reset_target", csr_branch_address, 32'd0);
    tick();
    rd(12'h300, 32'd0, "reset_mstatus");

    // Illegal instruction trap to M
    wr(12'h305, 32'h8000_0100);
    idle(); csr_trapID = 5'd2; csr_trapPC = 32'h1000; faulting_inst = 32'hFFFF_FFFF;
    settle();
    check("ill_branch", {31'd0, csr_branch_signal}, 32'd1);
    check("ill_target", csr_branch_address, 32'h8000_0100);
    tick();
    rd(12'h341, 32'h1000, "ill_mepc");
    rd(12'h342, 32'd2, "ill_mcause");
    rd(12'h343, 32'hFFFF_FFFF, "ill_mtval");
    rd(12'h300, 32'h1800, "ill_mstatus_mpp");

    // MRET to U
    wr(12'h300, 32'h80);
    wr(12'h341, 32'h2000);
    idle(); csr_mret = 1'b1;
    settle(); check("mret_target", csr_branch_address, 32'h2000); tick();
    idle(); settle();
    check("mret_priv", {30'd0, priv_o}, 32'd0);
    check("mret_status", csr_status, 32'h88);
    tick();

    // Delegated ECALL from U
    wr(12'h302, 32'h100);
    wr(12'h105, 32'hC000_0000);
    idle(); csr_ecall = 1'b1; csr_trapPC = 32'h4000;
    settle(); check("ecall_target", csr_branch_address, 32'hC000_0000); tick();
    idle(); csr_ren = 1'b1; csr_raddr = 12'h142; settle();
    check("ecall_scause", csr_rdata, 32'd8);
    check("ecall_priv", {30'd0, priv_o}, 32'd1);
    check("ecall_spp", {31'd0, csr_status[8]}, 32'd0);
    tick();
    rd(12'h141, 32'h4000, "ecall_sepc");

    // Timer interrupt from S
    wr(12'h304, 32'h80);
    idle(); mtip = 1'b1; csr_trapPC = 32'h5000;
    settle();
    check("irq_branch", {31'd0, csr_branch_signal}, 32'd1);
    check("irq_target", csr_branch_address, 32'h8000_0100);
    tick();
    idle(); csr_ren = 1'b1; csr_raddr = 12'h342; settle();
    check("irq_mcause", csr_rdata, 32'h8000_0007);
    check("irq_priv", {30'd0, priv_o}, 32'd3);
    check("irq_status", csr_status, 32'h880);
    tick();

    // Target forwarding: EX beats MEM, MEM beats stored
    idle(); csr_mret = 1'b1;
    csr_addr_EX = 12'h341; csr_rdata_EX = 32'h3000;
    csr_addr_MEM = 12'h341; csr_rdata_MEM = 32'h7000;
    settle(); check("fwd_ex_target", csr_branch_address, 32'h3000); tick();
    idle(); csr_sret = 1'b1;
    csr_addr_EX = 12'h305; csr_rdata_EX = 32'h9000;
    csr_addr_MEM = 12'h141; csr_rdata_MEM = 32'h6000;
    settle(); check("fwd_mem_target", csr_branch_address, 32'h6000); tick();

    // satp and SUM
    wr(12'h180, 32'h8000_0123);
    idle(); settle(); check("satp_o", satp_o, 32'h8000_0123); tick();
    wr(12'h100, 32'h0004_0000);
    idle(); settle();
    check("sum_out", sstatus_sum, 32'd1);
    check("sum_status", csr_status, 32'h0004_0088);
    tick();

    // Unimplemented address, epc alignment, read-during-write
    wr(12'h7C0, 32'hDEAD_BEEF);
    rd(12'h7C0, 32'd0, "unimpl_read");
    wr(12'h341, 32'h1237);
    rd(12'h341, 32'h1234, "mepc_align");
    wr(12'h340, 32'h1111);
    idle(); csr_wen = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'h2222;
    csr_ren = 1'b1; csr_raddr = 12'h340;
    settle(); check("rdw_old", csr_rdata, 32'h1111); tick();
    rd(12'h340, 32'h2222, "rdw_new");

    // Trap beats a concurrent write to mcause; load fault tval
    idle(); csr_trapID = 5'd5; csr_trapPC = 32'h8888; faulting_va_DMEM = 32'hABCD_0000;
    csr_wen = 1'b1; csr_waddr = 12'h342; csr_wdata = 32'hFFFF;
    settle(); tick();
    rd(12'h342, 32'd5, "trap_wins_mcause");
    rd(12'h343, 32'hABCD_0000, "load_fault_tval");

    // Reset with a trap pending discards it
    idle(); rst = 1'b1; csr_trapID = 5'd7; csr_trapPC = 32'h7777;
    settle(); tick();
    rd(12'h341, 32'd0, "rst_mid_trap_mepc");
    rd(12'h304, 32'd0, "rst_mie");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      idle();
      rst       = ($urandom_range(0, 299) == 0);
      csr_wen   = 1'($urandom_range(0, 1));
      csr_waddr = addrs[$urandom_range(0, 25)];
      csr_wdata = $urandom;
      if (csr_waddr == 12'h300) begin
        r = $urandom_range(0, 2);
        csr_wdata[12:11] = (r == 2) ? 2'b11 : 2'(r);
      end
      csr_ren   = ($urandom_range(0, 4) != 0);
      csr_raddr = addrs[$urandom_range(0, 25)];
      if ($urandom_range(0, 11) == 0) csr_trapID = 5'($urandom_range(1, 31));
      csr_ecall = ($urandom_range(0, 15) == 0);
      csr_mret  = ($urandom_range(0, 9) == 0);
      csr_sret  = ($urandom_range(0, 9) == 0);
      csr_trapPC       = $urandom;
      faulting_inst    = $urandom;
      faulting_va_IMEM = $urandom;
      faulting_va_DMEM = $urandom;
      csr_addr_EX   = fwd_addrs[$urandom_range(0, 5)];
      csr_addr_MEM  = fwd_addrs[$urandom_range(0, 5)];
      csr_rdata_EX  = $urandom & 32'hFFFF_FFFC;
      csr_rdata_MEM = $urandom & 32'hFFFF_FFFC;
      msip = ($urandom_range(0, 5) == 0);
      mtip = ($urandom_range(0, 5) == 0);
      meip = ($urandom_range(0, 5) == 0);
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_register_file.md
# csr_register_file

Machine/supervisor control-and-status register file for the RV32 pipeline. It holds the privileged CSRs, the current privilege level and the satp/SUM state consumed by the MMU. It takes exceptions, ECALL and interrupts, and executes MRET/SRET, giving the pipeline a redirect signal and target. It sits under the CSR handler and is read in decode and written from WB.

## Interface
No parameters.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- csr_wen  in  1  CSR write enable (WB)
- csr_waddr  in  12  write address
- csr_wdata  in  32  write data
- csr_ren  in  1  read enable
- csr_raddr  in  12  read address
- csr_rdata  out  32  combinational read data
- csr_status  out  32  current mstatus
- csr_trapPC  in  32  PC of faulting instruction / resume PC for interrupts
- csr_trapID  in  5  exception code (0 = none)
- faulting_inst  in  32  instruction word for illegal-instruction tval
- faulting_va_IMEM  in  32  fetch fault VA
- faulting_va_DMEM  in  32  load/store fault VA
- csr_ecall, csr_mret, csr_sret  in  1 each  decoded ECALL/MRET/SRET
- csr_branch_signal  out  1  redirect pipeline
- csr_branch_address  out  32  redirect target
- csr_addr_EX, csr_addr_MEM  in  12 each  in-flight CSR write addresses (0 = none)
- csr_rdata_EX, csr_rdata_MEM  in  32 each  in-flight CSR write data
- msip, mtip, meip  in  1 each  software/timer/external interrupt lines
- satp_o  out  32  satp
- priv_o  out  2  privilege (00 U, 01 S, 11 M)
- sstatus_sum  out  32  {31'b0, mstatus.SUM}

## Operation
- Implemented CSRs: sstatus 0x100 (restricted mstatus view), sie 0x104, stvec 0x105, sscratch 0x140, sepc 0x141, scause 0x142, stval 0x143, sip 0x144, satp 0x180, mstatus 0x300, misa 0x301 (RO 0x40141101), medeleg 0x302, mideleg 0x303, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, cycle 0xC00 (RO), mhartid 0xF14 (RO 0).
- Unimplemented addresses read 0 and ignore writes.
- mstatus writable bits: SIE1, MIE3, SPIE5, MPIE7, SPP8, MPP12:11, SUM18, MXR19; all others read 0.
- sstatus write mask: SIE, SPIE, SPP, SUM, MXR.
- mip/sip: bit3 = msip, bit7 = mtip, bit11 = meip, live; writes ignored. sip/sie expose bits 1/5/9 only.
- mepc/sepc bits[1:0] forced to 0. mcycle increments every cycle; a write overrides that cycle's increment.
- csr_rdata = value at csr_raddr when csr_ren, else 0.
- Event priority, evaluated each cycle: exception (csr_trapID≠0) > ecall > mret > sret > interrupt.
- Ecall cause = 8 / 9 / 11 for priv U / S / M.
- Interrupt taken when (mie & mip) ≠ 0 and (priv≠M or mstatus.MIE). Priority MEIP(11) > MSIP(3) > MTIP(7). mcause = 0x80000000 | code. Interrupts always go to M.
- Delegation: an exception goes to S when priv≠M and medeleg[cause] = 1; otherwise it goes to M.
- tval selection:
  - cause 2: faulting_inst
  - causes 1, 12: faulting_va_IMEM
  - causes 4-7, 13, 15: faulting_va_DMEM
  - all others: 0
- Trap to M: mepc = trapPC, mcause, mtval, MPIE = MIE, MIE = 0, MPP = priv, priv = M, target = {mtvec[31:2], 2'b00}.
- Trap to S: sepc, scause, stval, SPIE = SIE, SIE = 0, SPP = priv[0], priv = S, target = {stvec[31:2], 2'b00}.
- MRET: priv = MPP, MIE = MPIE, MPIE = 1, MPP = U, target = mepc.
- SRET: priv = {1'b0, SPP}, SIE = SPIE, SPIE = 1, SPP = 0, target = sepc.
- Target forwarding: a nonzero csr_addr_EX matching the tvec/epc being used selects csr_rdata_EX. Otherwise a match on csr_addr_MEM selects csr_rdata_MEM. Otherwise the stored value is used.

## Timing
- csr_rdata, csr_branch_signal, csr_branch_address, csr_status, satp_o, priv_o and sstatus_sum are combinational from current state and inputs.
- All state updates (trap, xret, csr_wen write) occur at the next posedge clk.
- csr_wen write and a trap/xret in the same cycle: the trap/xret fields win for the registers it modifies; the write applies to any other register.
- Read and write of the same address in the same cycle: read returns the old value.
- Reset: priv = M, misa constant, all other CSRs 0, csr_branch_signal = 0, csr_branch_address = 0 (with no trap inputs active). Reset mid-trap discards the trap.

## Test plan
- Reset, then read 0x301 and 0x300 -> 0x40141101 and 0; priv_o = 11.
- Write mtvec = 0x80000100, then assert trapID = 2 with trapPC = 0x1000 and faulting_inst = 0xFFFFFFFF -> branch to 0x80000100 the same cycle. Next cycle: mepc = 0x1000, mcause = 2, mtval = 0xFFFFFFFF, MPP = 11.
- MRET with MPP = 00 and mepc = 0x2000 -> target 0x2000; priv_o = 00 next cycle; mstatus.MIE = MPIE, MPIE = 1.
- priv U, medeleg[8] = 1, stvec = 0xC0000000, ecall -> target 0xC0000000; scause = 8, priv_o = 01, SPP = 0.
- mie[7] = 1, MIE = 1, pulse mtip -> branch to mtvec; mcause = 0x80000007.
- csr_addr_EX = 0x341 with csr_rdata_EX = 0x3000 while MRET executes -> target 0x3000. Write satp = 0x80000123 -> satp_o updates; SUM = 1 -> sstatus_sum = 1.
